kf_meas_input: RTL and testbench
================================

# kf_meas_input

Measurement-data-input stage of the Kalman filter pipeline: receives raw measurement samples as a beat-serial stream, assembles them into M_DIM-element measurement vectors, and buffers complete frames in a small frame FIFO. It drives the control unit's MDI_Valid and holds the current measurement vector steady for the covariance/state update stage until that stage consumes it. Malformed frames are rejected. Frames that complete while the buffer is full are dropped.

## Interface
- DATA_W, 64: width of one measurement element (IEEE-754 double bit pattern, opaque here)
- M_DIM, 6: elements per measurement frame, ≥2
- FRAME_DEPTH, 2: frame FIFO entries, power of two, ≥2
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  reset, synchronous and active-high
- s_data  in  DATA_W  measurement element
- s_valid  in  1  element beat present
- s_last  in  1  marks final beat of a frame
- s_ready  out  1  stream accept (stream is non-stallable; see Operation)
- mdi_valid  out  1  head frame available → control unit MDI_Valid
- mdi_vec  out  M_DIM*DATA_W  head frame; element i at bits [i*DATA_W +: DATA_W]
- mdi_consume  in  1  single-cycle pulse from update stage: pop head frame
- frame_err  out  1  one-cycle pulse on malformed frame
- drop_cnt  out  16  dropped-frame counter (only with KF_MDI_DROP_CNT_EN)

## Operation
- Beat accepted when s_valid && s_ready.
- s_ready registered: 0 in any cycle where rst is sampled high, 1 from the first cycle after rst deasserts. Never deasserted for backpressure.
- Assembler FSM, states FILL and DISCARD, element index idx 0..M_DIM-1.
- FILL, accepted beat:
  - Writes s_data into staging element idx.
  - s_last && idx==M_DIM-1: frame complete → commit; idx←0.
  - s_last && idx<M_DIM-1: short frame → frame_err pulse, staging discarded, idx←0, stay FILL.
  - !s_last && idx==M_DIM-1: long frame → frame_err pulse, no commit, go DISCARD.
  - Otherwise: idx←idx+1.
- DISCARD: accepted beats ignored. Accepted s_last → FILL, idx←0. No second frame_err.
- Commit: copies the whole staging vector into the FIFO at wr_ptr if count<FRAME_DEPTH.
  - Full and mdi_consume in the same cycle: pop and push both happen; no drop.
  - Full without consume: frame dropped (newest dropped). The head and all queued frames are untouched.
- mdi_valid = (count≠0). mdi_vec = entry at rd_ptr. mdi_vec is stable while mdi_valid is high and no consume occurs.
- mdi_consume with count==0 is ignored.
- Pointers wrap modulo FRAME_DEPTH. count is 0..FRAME_DEPTH inclusive.
- Reset values: s_ready 0, mdi_valid 0, mdi_vec 0, frame_err 0, drop_cnt 0, idx 0, FSM FILL, pointers/count 0, staging 0.
- Reset mid-frame: partial frame and all buffered frames are discarded. The first post-reset beat is treated as element 0.

## Timing
- Last beat accepted in cycle N → mdi_valid=1 and mdi_vec valid in cycle N+1 (FIFO was empty).
- mdi_consume in cycle N → next frame (or mdi_valid=0) in cycle N+1.
- frame_err asserted in cycle N+1 for the offending beat in cycle N, for exactly one cycle.
- Back-to-back frames at one beat/cycle are sustained with no bubble.

## Configuration
- KF_MDI_DROP_CNT_EN defined:
  - drop_cnt increments by 1 per dropped frame and saturates at 16'hFFFF.
  - Cleared only by rst.
- Undefined: drop_cnt port absent, counter logic removed. Drop behaviour is otherwise identical.

## Structure
- kf_pkg holds:
  - typedef enum mdi_asm_state_t {FILL, DISCARD}
  - localparam KF_MDI_DROP_CNT_W = 16
- One sub-module, kf_mdi_frame_fifo: FRAME_DEPTH × (M_DIM*DATA_W) storage, pointers, count, and push/pop with the same-cycle rule above.
- The assembler FSM, staging register and drop counter live in the top module.

## Test plan
- Reset: hold rst 3 cycles → all outputs 0, s_ready 0 while rst high and 1 one cycle after release.
- Good frame: beats 1..6, s_last on 6 → mdi_valid at next cycle, element 0 = 1 and element 5 = 6. mdi_consume pulse → mdi_valid 0 next cycle.
- Short frame: s_last on beat 3 → frame_err single pulse, mdi_valid stays 0. A following good frame 10..15 is delivered intact.
- Long frame: 8 beats, s_last on beat 8 → frame_err once (after beat 6), no commit. A following good frame is delivered correctly.
- Overflow: 3 good frames A,B,C with no consume → C dropped, drop_cnt=1, head=A. Repeat with consume pulsed in C's commit cycle → no drop, FIFO holds B,C.
- Reset mid-operation: one frame buffered plus 3 beats of a second, assert rst → mdi_valid 0. A new 6-beat frame after reset is delivered as element 0..5.

Source files
------------

// File: rtl/kf_pkg.sv
// Shared types and constants for the Kalman filter measurement-input stage.
package kf_pkg;

  typedef enum logic [0:0] {
    FILL    = 1'b0,
    DISCARD = 1'b1
  } mdi_asm_state_t;

  localparam int KF_MDI_DROP_CNT_W = 16;

  // Saturating increment used by the optional dropped-frame counter.
  function automatic logic [KF_MDI_DROP_CNT_W-1:0] sat_inc(
    input logic [KF_MDI_DROP_CNT_W-1:0] v
  );
    if (v == {KF_MDI_DROP_CNT_W{1'b1}}) begin
      return v;
    end else begin
      return v + KF_MDI_DROP_CNT_W'(1);
    end
  endfunction

endpackage

// File: rtl/kf_mdi_frame_fifo.sv
// Frame FIFO holding complete measurement vectors; a push into a full FIFO
// succeeds only when a pop happens in the same cycle, otherwise it is dropped.
module kf_mdi_frame_fifo #(
  parameter int VEC_W       = 384,
  parameter int FRAME_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_req,
  input  logic [VEC_W-1:0] push_data,
  input  logic             pop_req,
  output logic             head_valid,
  output logic [VEC_W-1:0] head_data,
  output logic             push_drop
);

  localparam int PTR_W = (FRAME_DEPTH > 1) ? $clog2(FRAME_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [VEC_W-1:0] mem_r [FRAME_DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;

  logic full_s;
  logic pop_s;
  logic push_s;

  assign full_s    = (count_r == CNT_W'(FRAME_DEPTH));
  assign pop_s     = pop_req && (count_r != {CNT_W{1'b0}});
  assign push_s    = push_req && (!full_s || pop_s);
  assign push_drop = push_req && full_s && !pop_s;

  assign head_valid = (count_r != {CNT_W{1'b0}});
  assign head_data  = mem_r[rd_ptr_r];

  // Storage, pointers and occupancy; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      for (int i = 0; i < FRAME_DEPTH; i++) begin
        mem_r[i] <= {VEC_W{1'b0}};
      end
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/kf_meas_input.sv
// Measurement-data-input stage: assembles beat-serial samples into M_DIM-element
// frames and buffers them for the update stage. Optional KF_MDI_DROP_CNT_EN adds drop_cnt.
module kf_meas_input
  import kf_pkg::*;
#(
  parameter int DATA_W      = 64,
  parameter int M_DIM       = 6,
  parameter int FRAME_DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_W-1:0]         s_data,
  input  logic                      s_valid,
  input  logic                      s_last,
  output logic                      s_ready,
  output logic                      mdi_valid,
  output logic [M_DIM*DATA_W-1:0]   mdi_vec,
  input  logic                      mdi_consume,
  output logic                      frame_err
`ifdef KF_MDI_DROP_CNT_EN
  ,
  output logic [KF_MDI_DROP_CNT_W-1:0] drop_cnt
`endif
);

  localparam int VEC_W = M_DIM * DATA_W;
  localparam int IDX_W = $clog2(M_DIM);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(M_DIM - 1);

  mdi_asm_state_t    state_r;
  mdi_asm_state_t    state_nxt_s;
  logic [IDX_W-1:0]  idx_r;
  logic [IDX_W-1:0]  idx_nxt_s;
  logic [VEC_W-1:0]  stage_r;
  logic [VEC_W-1:0]  push_vec_s;
  logic              s_ready_r;
  logic              frame_err_r;
  logic              accept_s;
  logic              commit_s;
  logic              err_s;
  logic              stage_we_s;
  logic              drop_s;

  assign accept_s  = s_valid && s_ready_r;
  assign s_ready   = s_ready_r;
  assign frame_err = frame_err_r;

  // Assembler state and element index register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= FILL;
      idx_r   <= {IDX_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      idx_r   <= idx_nxt_s;
    end
  end

  // Next-state decode: a missing s_last on the final element sends the rest of the frame to DISCARD.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      FILL: begin
        if (accept_s && !s_last && (idx_r == LAST_IDX)) begin
          state_nxt_s = DISCARD;
        end else begin
          state_nxt_s = FILL;
        end
      end
      DISCARD: begin
        if (accept_s && s_last) begin
          state_nxt_s = FILL;
        end else begin
          state_nxt_s = DISCARD;
        end
      end
      default: state_nxt_s = FILL;
    endcase
  end

  // Per-beat actions: staging write, commit, framing error and index update.
  always_comb begin
    commit_s   = 1'b0;
    err_s      = 1'b0;
    stage_we_s = 1'b0;
    idx_nxt_s  = idx_r;
    case (state_r)
      FILL: begin
        if (accept_s) begin
          stage_we_s = 1'b1;
          if (s_last) begin
            idx_nxt_s = {IDX_W{1'b0}};
            if (idx_r == LAST_IDX) begin
              commit_s = 1'b1;
            end else begin
              err_s = 1'b1;
            end
          end else if (idx_r == LAST_IDX) begin
            err_s     = 1'b1;
            idx_nxt_s = {IDX_W{1'b0}};
          end else begin
            idx_nxt_s = idx_r + IDX_W'(1);
          end
        end else begin
          idx_nxt_s = idx_r;
        end
      end
      DISCARD: begin
        if (accept_s && s_last) begin
          idx_nxt_s = {IDX_W{1'b0}};
        end else begin
          idx_nxt_s = idx_r;
        end
      end
      default: idx_nxt_s = {IDX_W{1'b0}};
    endcase
  end

  // Stream accept and framing-error pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_ready_r   <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      s_ready_r   <= 1'b1;
      frame_err_r <= err_s;
    end
  end

  // Staging vector, one element per accepted beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage_r <= {VEC_W{1'b0}};
    end else if (stage_we_s) begin
      for (int i = 0; i < M_DIM; i++) begin
        if (idx_r == IDX_W'(i)) begin
          stage_r[i*DATA_W +: DATA_W] <= s_data;
        end
      end
    end else begin
      stage_r <= stage_r;
    end
  end

  // The final element arrives on the commit beat itself, so it bypasses staging.
  always_comb begin
    push_vec_s = stage_r;
    push_vec_s[(M_DIM-1)*DATA_W +: DATA_W] = s_data;
  end

  kf_mdi_frame_fifo #(
    .VEC_W       (VEC_W),
    .FRAME_DEPTH (FRAME_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_req   (commit_s),
    .push_data  (push_vec_s),
    .pop_req    (mdi_consume),
    .head_valid (mdi_valid),
    .head_data  (mdi_vec),
    .push_drop  (drop_s)
  );

`ifdef KF_MDI_DROP_CNT_EN
  logic [KF_MDI_DROP_CNT_W-1:0] drop_cnt_r;

  // Saturating dropped-frame counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt_r <= {KF_MDI_DROP_CNT_W{1'b0}};
    end else if (drop_s) begin
      drop_cnt_r <= sat_inc(drop_cnt_r);
    end else begin
      drop_cnt_r <= drop_cnt_r;
    end
  end

  assign drop_cnt = drop_cnt_r;
`else
  logic drop_unused_s;
  assign drop_unused_s = drop_s;
`endif

endmodule

// File: tb/tb_kf_meas_input.sv
// Directed scoreboard bench for kf_meas_input (drop_cnt checked when KF_MDI_DROP_CNT_EN is defined).
module tb_kf_meas_input;
  import kf_pkg::*;

  localparam int DATA_W      = 64;
  localparam int M_DIM       = 6;
  localparam int FRAME_DEPTH = 2;
  localparam int VEC_W       = M_DIM * DATA_W;

  logic              clk = 1'b0;
  logic              rst;
  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_last;
  logic              s_ready;
  logic              mdi_valid;
  logic [VEC_W-1:0]  mdi_vec;
  logic              mdi_consume;
  logic              frame_err;
`ifdef KF_MDI_DROP_CNT_EN
  logic [KF_MDI_DROP_CNT_W-1:0] drop_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;
  int exp_drop = 0;
  logic [VEC_W-1:0] exp_q [$];

  always #5 clk = ~clk;

  kf_meas_input #(
    .DATA_W      (DATA_W),
    .M_DIM       (M_DIM),
    .FRAME_DEPTH (FRAME_DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_last      (s_last),
    .s_ready     (s_ready),
    .mdi_valid   (mdi_valid),
    .mdi_vec     (mdi_vec),
    .mdi_consume (mdi_consume),
    .frame_err   (frame_err)
`ifdef KF_MDI_DROP_CNT_EN
    ,
    .drop_cnt    (drop_cnt)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [VEC_W-1:0] obs, input logic [VEC_W-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [VEC_W-1:0] mk_vec(input int base);
    logic [VEC_W-1:0] v;
    for (int i = 0; i < M_DIM; i++) begin
      v[i*DATA_W +: DATA_W] = DATA_W'(base + i);
    end
    return v;
  endfunction

  task automatic chk_head(input string tag);
    chk({tag, " valid"}, VEC_W'(mdi_valid), VEC_W'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      chk({tag, " vec"}, mdi_vec, exp_q[0]);
    end
  endtask

  // Drives n beats from base; updates the scoreboard on the final beat.
  task automatic send(input int base, input int n, input bit with_last,
                      input bit consume_last, input string tag);
    int errs;
    int exp_errs;
    bit good;
    errs     = 0;
    good     = with_last && (n == M_DIM);
    exp_errs = ((n > M_DIM) || (with_last && (n < M_DIM))) ? 1 : 0;
    for (int i = 0; i < n; i++) begin
      s_valid = 1'b1;
      s_data  = DATA_W'(base + i);
      s_last  = with_last && (i == n - 1);
      if ((i == n - 1) && consume_last) begin
        if (exp_q.size() != 0) chk({tag, " head before consume"}, mdi_vec, exp_q[0]);
        mdi_consume = 1'b1;
      end
      step();
      mdi_consume = 1'b0;
      if (frame_err) errs++;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    if (consume_last && (exp_q.size() != 0)) void'(exp_q.pop_front());
    if (good) begin
      if (exp_q.size() < FRAME_DEPTH) exp_q.push_back(mk_vec(base));
      else exp_drop++;
    end
    chk({tag, " frame_err pulses"}, VEC_W'(errs), VEC_W'(exp_errs));
    chk_head(tag);
    if (exp_errs != 0) begin
      step();
      chk({tag, " frame_err width"}, VEC_W'(frame_err), VEC_W'(0));
    end
  endtask

  task automatic consume(input string tag);
    mdi_consume = 1'b1;
    step();
    mdi_consume = 1'b0;
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    chk_head(tag);
  endtask

  task automatic chk_drop(input string tag);
`ifdef KF_MDI_DROP_CNT_EN
    chk(tag, VEC_W'(drop_cnt), VEC_W'(exp_drop));
`endif
  endtask

  initial begin
    rst = 1'b1; s_data = '0; s_valid = 1'b0; s_last = 1'b0; mdi_consume = 1'b0;

    // Reset held three cycles.
    for (int c = 0; c < 3; c++) begin
      step();
      chk("reset s_ready", VEC_W'(s_ready), VEC_W'(0));
      chk("reset mdi_valid", VEC_W'(mdi_valid), VEC_W'(0));
      chk("reset frame_err", VEC_W'(frame_err), VEC_W'(0));
      chk("reset mdi_vec", mdi_vec, VEC_W'(0));
    end
    chk_drop("reset drop_cnt");
    rst = 1'b0;
    step();
    chk("s_ready after release", VEC_W'(s_ready), VEC_W'(1));

    // Good frame 1..6 then consume.
    send(1, 6, 1'b1, 1'b0, "good");
    chk("good elem0", VEC_W'(mdi_vec[0 +: DATA_W]), VEC_W'(1));
    chk("good elem5", VEC_W'(mdi_vec[5*DATA_W +: DATA_W]), VEC_W'(6));
    consume("good consume");

    // Short frame followed by a good one.
    send(20, 3, 1'b1, 1'b0, "short");
    send(10, 6, 1'b1, 1'b0, "after short");
    consume("after short consume");

    // Long frame followed by a good one.
    send(30, 8, 1'b1, 1'b0, "long");
    send(40, 6, 1'b1, 1'b0, "after long");
    consume("after long consume");

    // Overflow: C dropped, A then B delivered.
    send(50, 6, 1'b1, 1'b0, "ovf A");
    send(60, 6, 1'b1, 1'b0, "ovf B");
    send(70, 6, 1'b1, 1'b0, "ovf C");
    chk("ovf drops expected", VEC_W'(exp_drop), VEC_W'(1));
    chk_drop("ovf drop_cnt");
    consume("ovf pop A");
    consume("ovf pop B");

    // Full FIFO with consume on the commit beat: no drop.
    send(110, 6, 1'b1, 1'b0, "ovf2 D");
    send(120, 6, 1'b1, 1'b0, "ovf2 E");
    send(130, 6, 1'b1, 1'b1, "ovf2 F");
    chk_drop("ovf2 drop_cnt");
    consume("ovf2 pop E");
    consume("ovf2 pop F");

    // Consume while empty is ignored.
    consume("empty consume");

    // Reset mid-operation.
    send(80, 6, 1'b1, 1'b0, "pre-reset frame");
    send(90, 3, 1'b0, 1'b0, "pre-reset partial");
    rst = 1'b1;
    step();
    exp_q.delete();
    exp_drop = 0;
    chk("mid reset mdi_valid", VEC_W'(mdi_valid), VEC_W'(0));
    chk("mid reset s_ready", VEC_W'(s_ready), VEC_W'(0));
    chk_drop("mid reset drop_cnt");
    rst = 1'b0;
    step();
    send(100, 6, 1'b1, 1'b0, "post-reset");
    chk("post-reset elem0", VEC_W'(mdi_vec[0 +: DATA_W]), VEC_W'(100));
    consume("post-reset consume");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
